// File: rtl/wb_sram_responder_if.sv
// rtl/wb_sram_responder_if.sv - Wishbone B4 pipelined bus bundle between a master and the SRAM responder
interface wb_sram_responder_if;
  logic        cyc;
  logic        stb;
  logic        we;
  logic [31:0] adr;
  logic [3:0]  sel;
  logic [31:0] dat_i;
  logic [31:0] dat_o;
  logic        ack;
  logic        err;
  logic        stall;

  modport master (
    output cyc, stb, we, adr, sel, dat_i,
    input  dat_o, ack, err, stall
  );

  modport slave (
    input  cyc, stb, we, adr, sel, dat_i,
    output dat_o, ack, err, stall
  );
endinterface

// File: rtl/wb_sram_responder.sv
// rtl/wb_sram_responder.sv - Wishbone B4 pipelined SRAM responder with fixed-latency ack/err and outstanding-count stall
module wb_sram_responder #(
  parameter int DEPTH   = 1024,
  parameter int LATENCY = 1,
  parameter int MAX_OUT = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  wb_sram_responder_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(MAX_OUT + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(MAX_OUT);

  logic [31:0]   r_mem [DEPTH];
  logic          r_vld [LATENCY];
  logic          r_err [LATENCY];
  logic [31:0]   r_dat [LATENCY];
  logic [CW-1:0] r_cnt;

  logic          w_accept;
  logic          w_in_range;
  logic          w_emit;
  logic [AW-1:0] w_idx;
  logic [31:0]   w_wmask;

  assign w_idx      = bus.adr[AW+1:2];
  assign w_in_range = (bus.adr[31:AW+2] == '0);
  assign w_wmask    = {{8{bus.sel[3]}}, {8{bus.sel[2]}}, {8{bus.sel[1]}}, {8{bus.sel[0]}}};
  // rst_n gate keeps the unreset SRAM from taking a write while reset is held
  assign w_accept   = rst_n & bus.cyc & bus.stb & ~bus.stall;
  assign w_emit     = r_vld[LATENCY-1];

  assign bus.stall  = (r_cnt == CNT_MAX);
  assign bus.ack    = bus.cyc & r_vld[LATENCY-1] & ~r_err[LATENCY-1];
  assign bus.err    = bus.cyc & r_vld[LATENCY-1] &  r_err[LATENCY-1];
  assign bus.dat_o  = bus.ack ? r_dat[LATENCY-1] : '0;

  always_ff @(posedge clk) begin
    if (w_accept && bus.we && w_in_range) begin
      r_mem[w_idx] <= (r_mem[w_idx] & ~w_wmask) | (bus.dat_i & w_wmask);
    end
  end

  // Read data is captured at acceptance and rides the pipeline with its response
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
      for (int i = 0; i < LATENCY; i++) begin
        r_vld[i] <= 1'b0;
        r_err[i] <= 1'b0;
        r_dat[i] <= '0;
      end
    end else if (!bus.cyc) begin
      r_cnt <= '0;
      for (int i = 0; i < LATENCY; i++) begin
        r_vld[i] <= 1'b0;
      end
    end else begin
      r_vld[0] <= w_accept;
      r_err[0] <= w_accept & ~w_in_range;
      r_dat[0] <= (w_accept && !bus.we && w_in_range) ? r_mem[w_idx] : '0;
      for (int i = 1; i < LATENCY; i++) begin
        r_vld[i] <= r_vld[i-1];
        r_err[i] <= r_err[i-1];
        r_dat[i] <= r_dat[i-1];
      end
      if (w_accept && !w_emit) begin
        r_cnt <= r_cnt + 1'b1;
      end else if (!w_accept && w_emit) begin
        r_cnt <= r_cnt - 1'b1;
      end
    end
  end

`ifndef SYNTHESIS
  a_onehot_resp: assert property (@(posedge clk) disable iff (!rst_n) $onehot0({bus.ack, bus.err}));
  a_cnt_bound:   assert property (@(posedge clk) disable iff (!rst_n) r_cnt <= CNT_MAX);
  a_no_resp_idle: assert property (@(posedge clk) disable iff (!rst_n) !bus.cyc |-> !(bus.ack || bus.err));
`endif
endmodule

// File: tb/tb_wb_sram_responder.sv
// tb/tb_wb_sram_responder.sv - randomized bench for wb_sram_responder against a queue-based bus model
module tb_wb_sram_responder;
  localparam int DEPTH   = 1024;
  localparam int LATENCY = 3;
  localparam int MAX_OUT = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  wb_sram_responder_if bus();

  wb_sram_responder #(.DEPTH(DEPTH), .LATENCY(LATENCY), .MAX_OUT(MAX_OUT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Each accepted request becomes one expected response, due at a given edge count
  typedef struct {
    int          due;
    logic        is_err;
    logic        is_rd;
    logic [31:0] data;
  } resp_t;

  resp_t       q[$];
  logic [31:0] ack_log[$];
  logic [31:0] mem_m [DEPTH];
  int          n_edge = 0;
  int          n_vec  = 0;
  int          n_bad  = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_outputs();
    logic        exp_ack;
    logic        exp_err;
    logic        rd;
    logic [31:0] exp_dat;
    exp_ack = 1'b0;
    exp_err = 1'b0;
    rd      = 1'b0;
    exp_dat = '0;
    if (bus.cyc && q.size() > 0 && q[0].due == n_edge) begin
      exp_err = q[0].is_err;
      exp_ack = ~q[0].is_err;
      rd      = q[0].is_rd;
      exp_dat = (q[0].is_rd && !q[0].is_err) ? q[0].data : '0;
    end
    chk("stall", 32'(bus.stall), 32'(q.size() == MAX_OUT));
    chk("ack",   32'(bus.ack),   32'(exp_ack));
    chk("err",   32'(bus.err),   32'(exp_err));
    if (!(exp_ack && !rd)) chk("dat_o", bus.dat_o, exp_dat);
    if (bus.ack) ack_log.push_back(bus.dat_o);
  endtask

  // Drive one cycle from a negedge, advance the model across the edge, check at the next negedge
  task automatic step(input logic c, input logic s, input logic w, input logic [31:0] a,
                      input logic [3:0] sl, input logic [31:0] d, output logic acc);
    resp_t r;
    int    widx;
    bus.cyc = c; bus.stb = s; bus.we = w; bus.adr = a; bus.sel = sl; bus.dat_i = d;
    acc = c && s && (q.size() != MAX_OUT);
    if (!c) begin
      q.delete();
    end else begin
      if (q.size() > 0 && q[0].due == n_edge) void'(q.pop_front());
      if (acc) begin
        widx     = int'(a >> 2);
        r.due    = n_edge + LATENCY;
        r.is_rd  = ~w;
        r.is_err = ((a >> 2) >= DEPTH);
        r.data   = '0;
        if (!r.is_err && w) begin
          for (int i = 0; i < 4; i++) if (sl[i]) mem_m[widx][8*i +: 8] = d[8*i +: 8];
        end else if (!r.is_err) begin
          r.data = mem_m[widx];
        end
        q.push_back(r);
      end
    end
    n_edge++;
    @(posedge clk);
    @(negedge clk);
    check_outputs();
  endtask

  task automatic idle(input int k);
    logic acc;
    repeat (k) step(1'b1, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0, acc);
  endtask

  task automatic xfer(input logic w, input logic [31:0] a, input logic [3:0] sl, input logic [31:0] d);
    logic acc;
    int   t;
    acc = 1'b0;
    t   = 0;
    while (!acc && t < 20) begin
      step(1'b1, 1'b1, w, a, sl, d, acc);
      t++;
    end
    chk("accept", 32'(acc), 32'd1);
  endtask

  task automatic rd_expect(input string tag, input logic [31:0] a, input logic [31:0] exp);
    xfer(1'b0, a, 4'hF, 32'h0);
    idle(LATENCY - 1);
    chk({tag, "_ack"}, 32'(bus.ack), 32'd1);
    chk({tag, "_dat"}, bus.dat_o, exp);
    idle(1);
  endtask

  logic        acc_r;
  logic        pend;
  logic        rc, rs, rw;
  logic [31:0] ra, rd_v;
  logic [3:0]  rsel;
  int          issued, tries, sw;

  initial begin
    bus.cyc = 1'b0; bus.stb = 1'b0; bus.we = 1'b0;
    bus.adr = '0; bus.sel = '0; bus.dat_i = '0;
    for (int i = 0; i < DEPTH; i++) mem_m[i] = '0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_stall", 32'(bus.stall), 32'd0);
    chk("rst_ack",   32'(bus.ack),   32'd0);
    chk("rst_err",   32'(bus.err),   32'd0);
    chk("rst_dat",   bus.dat_o,      32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 16; i++) xfer(1'b1, 32'(i * 4), 4'hF, $urandom);
    xfer(1'b1, 32'hFFC, 4'hF, $urandom);
    idle(LATENCY + 1);

    xfer(1'b1, 32'h10, 4'hF, 32'hDEADBEEF);
    idle(LATENCY);
    rd_expect("t1", 32'h10, 32'hDEADBEEF);

    xfer(1'b1, 32'h10, 4'b0101, 32'h11223344);
    idle(LATENCY);
    rd_expect("t2_lanes", 32'h10, 32'hDE22BE44);
    xfer(1'b1, 32'h10, 4'b0000, 32'hFFFFFFFF);
    idle(LATENCY);
    rd_expect("t2_sel0", 32'h10, 32'hDE22BE44);

    for (int i = 0; i < 4; i++) xfer(1'b1, 32'(i * 4), 4'hF, 32'(i + 1));
    idle(LATENCY + 1);
    ack_log.delete();
    issued = 0;
    tries  = 0;
    while (issued < 4 && tries < 40) begin
      step(1'b1, 1'b1, 1'b0, 32'(issued * 4), 4'hF, 32'h0, acc_r);
      if (acc_r) begin
        issued++;
        if (issued == 2) chk("t3_stall_after2", 32'(bus.stall), 32'd1);
      end
      tries++;
    end
    chk("t3_issued", 32'(issued), 32'd4);
    idle(LATENCY + 2);
    chk("t3_nacks", 32'(ack_log.size()), 32'd4);
    for (int i = 0; i < 4; i++) chk("t3_order", (i < ack_log.size()) ? ack_log[i] : 32'hX, 32'(i + 1));

    xfer(1'b0, 32'h1000, 4'hF, 32'h0);
    idle(LATENCY - 1);
    chk("t4_rd_err", 32'(bus.err), 32'd1);
    chk("t4_rd_ack", 32'(bus.ack), 32'd0);
    chk("t4_rd_dat", bus.dat_o, 32'd0);
    idle(1);
    xfer(1'b1, 32'h1000, 4'hF, 32'hA5A5A5A5);
    idle(LATENCY - 1);
    chk("t4_wr_err", 32'(bus.err), 32'd1);
    idle(1);
    rd_expect("t4_word0", 32'h0, 32'd1);
    xfer(1'b0, 32'h4, 4'hF, 32'h0);
    xfer(1'b0, 32'h8000_0000, 4'hF, 32'h0);
    xfer(1'b0, 32'h8, 4'hF, 32'h0);
    idle(LATENCY + 2);

    xfer(1'b0, 32'h0, 4'hF, 32'h0);
    xfer(1'b0, 32'h4, 4'hF, 32'h0);
    for (int i = 0; i < LATENCY + 2; i++) begin
      step(1'b0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0, acc_r);
      chk("t5_no_resp", 32'(bus.ack | bus.err), 32'd0);
    end
    idle(1);
    chk("t5_stall", 32'(bus.stall), 32'd0);
    rd_expect("t5_after", 32'h8, 32'd3);

    xfer(1'b0, 32'hC, 4'hF, 32'h0);
    xfer(1'b0, 32'h0, 4'hF, 32'h0);
    idle(LATENCY - 2);
    chk("t6_pre_ack", 32'(bus.ack), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_ack", 32'(bus.ack),   32'd0);
    chk("t6_err", 32'(bus.err),   32'd0);
    chk("t6_stall", 32'(bus.stall), 32'd0);
    chk("t6_dat", bus.dat_o,       32'd0);
    q.delete();
    bus.cyc = 1'b0; bus.stb = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    idle(1);
    rd_expect("t6_w4", 32'h10, 32'hDE22BE44);
    rd_expect("t6_w3", 32'hC, 32'd4);

    pend = 1'b0;
    rc = 1'b1; rs = 1'b0; rw = 1'b0; ra = '0; rsel = '0; rd_v = '0;
    for (int k = 0; k < 800; k++) begin
      if (!pend) begin
        rc   = ($urandom_range(0, 99) < 96);
        rs   = ($urandom_range(0, 99) < 60);
        rw   = 1'($urandom_range(0, 1));
        sw   = int'($urandom_range(0, 9));
        if (sw < 8)       ra = 32'(($urandom_range(0, 15) << 2) | $urandom_range(0, 3));
        else if (sw == 8) ra = 32'hFFC;
        else              ra = 32'h1000 | $urandom;
        rsel = 4'($urandom);
        rd_v = $urandom;
      end
      step(rc, rs, rw, ra, rsel, rd_v, acc_r);
      pend = rc && rs && !acc_r;
    end
    idle(LATENCY + 2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
endmodule
